// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin share of the GPR write port with a pending-write scoreboard.
// Define GPR_WB_FWD_EN to add writeback forwarding outputs that mask pend_rs/pend_rt.
module gpr_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_rw,
    input  logic [NREQ*DW-1:0] req_data,
    output logic              gpr_wr,
    output logic [AW-1:0]     gpr_rw,
    output logic [DW-1:0]     gpr_busw,
    input  logic              claim_valid,
    input  logic [AW-1:0]     claim_rw,
    input  logic [AW-1:0]     rs,
    input  logic [AW-1:0]     rt,
`ifdef GPR_WB_FWD_EN
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DW-1:0]     fwd_data,
`endif
    output logic              pend_rs,
    output logic              pend_rt
);
    localparam int PW = $clog2(NREQ);
    localparam int NR = 1 << AW;

    logic [PW-1:0] ptr, idx, gidx;
    logic          found;
    logic [AW-1:0] rw_a [NREQ];
    logic [DW-1:0] data_a [NREQ];
    logic [NR-1:0] pend, set_mask, clr_mask;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rw_a[i]   = req_rw[i*AW +: AW];
        assign data_a[i] = req_data[i*DW +: DW];
    end

    // Walk from ptr, wrapping, and take the first valid requester.
    always_comb begin
        idx = ptr;
        gidx = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx = idx;
            end
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign req_ready = found ? NREQ'(1) << gidx : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gpr_wr   <= 1'b0;
            gpr_rw   <= '0;
            gpr_busw <= '0;
            ptr      <= '0;
        end else begin
            gpr_wr <= found && (rw_a[gidx] != '0);
            if (found) begin
                gpr_rw   <= rw_a[gidx];
                gpr_busw <= data_a[gidx];
                ptr      <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    // Set is applied after clear so a new claim beats the retiring write.
    assign set_mask = claim_valid ? NR'(1) << claim_rw : '0;
    assign clr_mask = gpr_wr ? NR'(1) << gpr_rw : '0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            pend <= '0;
        else
            pend <= ((pend & ~clr_mask) | set_mask) & ~NR'(1);
    end

`ifdef GPR_WB_FWD_EN
    assign fwd_rs_hit = gpr_wr && gpr_rw == rs && rs != '0;
    assign fwd_rt_hit = gpr_wr && gpr_rw == rt && rt != '0;
    assign fwd_data   = gpr_busw;
    assign pend_rs    = pend[rs] && !fwd_rs_hit;
    assign pend_rt    = pend[rt] && !fwd_rt_hit;
`else
    assign pend_rs = pend[rs];
    assign pend_rt = pend[rt];
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed and random checks of gpr_wb_arbiter against a queue-free behavioural model.
module tb_gpr_wb_arbiter;
    logic        clk, clr_n;
    logic        t_v [3];
    logic [4:0]  t_rw [3];
    logic [31:0] t_data [3];
    logic [2:0]  req_valid, req_ready;
    logic [14:0] req_rw;
    logic [95:0] req_data;
    logic        gpr_wr, claim_valid, pend_rs, pend_rt;
    logic [4:0]  gpr_rw, claim_rw, rs, rt;
    logic [31:0] gpr_busw;
`ifdef GPR_WB_FWD_EN
    logic        fwd_rs_hit, fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    assign req_valid = {t_v[2], t_v[1], t_v[0]};
    assign req_rw    = {t_rw[2], t_rw[1], t_rw[0]};
    assign req_data  = {t_data[2], t_data[1], t_data[0]};

    gpr_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_data(req_data),
        .gpr_wr(gpr_wr), .gpr_rw(gpr_rw), .gpr_busw(gpr_busw),
        .claim_valid(claim_valid), .claim_rw(claim_rw), .rs(rs), .rt(rt),
`ifdef GPR_WB_FWD_EN
        .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit), .fwd_data(fwd_data),
`endif
        .pend_rs(pend_rs), .pend_rt(pend_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Model state: what the register-file port and scoreboard must hold.
    int          m_ptr, acc;
    logic        m_wr;
    logic [4:0]  m_rw;
    logic [31:0] m_data;
    bit          m_pend [32];

    function automatic int first_valid(input int p);
        for (int k = 0; k < 3; k++)
            if (t_v[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ptr = 0; m_wr = 1'b0; m_rw = '0; m_data = '0; acc = -1;
            foreach (m_pend[n]) m_pend[n] = 1'b0;
        end else begin
            acc = first_valid(m_ptr);
            if (m_wr) m_pend[m_rw] = 1'b0;
            if (claim_valid && claim_rw != 0) m_pend[claim_rw] = 1'b1;
            if (acc >= 0) begin
                m_wr = t_rw[acc] != 0; m_rw = t_rw[acc]; m_data = t_data[acc];
                m_ptr = (acc + 1) % 3;
            end else
                m_wr = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int g;
        logic e_rs, e_rt;
        g = first_valid(m_ptr);
        chk("ready", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
        chk("gpr_wr", 32'(gpr_wr), 32'(m_wr));
        chk("gpr_rw", 32'(gpr_rw), 32'(m_rw));
        chk("gpr_busw", gpr_busw, m_data);
        e_rs = m_pend[rs];
        e_rt = m_pend[rt];
`ifdef GPR_WB_FWD_EN
        chk("fwd_rs_hit", 32'(fwd_rs_hit), 32'(m_wr && m_rw == rs && rs != 0));
        chk("fwd_rt_hit", 32'(fwd_rt_hit), 32'(m_wr && m_rw == rt && rt != 0));
        chk("fwd_data", fwd_data, m_data);
        if (m_wr && m_rw == rs && rs != 0) e_rs = 1'b0;
        if (m_wr && m_rw == rt && rt != 0) e_rt = 1'b0;
`endif
        chk("pend_rs", 32'(pend_rs), 32'(e_rs));
        chk("pend_rt", 32'(pend_rt), 32'(e_rt));
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic to_check;
        @(negedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        t_v[i] = v; t_rw[i] = r; t_data[i] = d;
    endtask

    initial begin
        clr_n = 1'b0; claim_valid = 1'b0; claim_rw = '0; rs = 5'd9; rt = '0;
        set_req(0, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 5'd2, 32'hA1);
        set_req(2, 1'b1, 5'd3, 32'hA2);
        // Reset holds: ready points at requester 0, nothing accepted.
        to_check;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_wr", 32'(gpr_wr), 0);
        tick; tick; to_check;
        chk("rst_ready2", 32'(req_ready), 32'h1);
        chk("rst_wr2", 32'(gpr_wr), 0);
        chk("rst_pend", 32'(pend_rs), 0);
        clr_n = 1'b1;
        // Round-robin across three continuously valid requesters.
        tick; to_check;
        chk("rr0_rw", 32'(gpr_rw), 1); chk("rr0_data", gpr_busw, 32'hA0);
        chk("rr0_wr", 32'(gpr_wr), 1); chk("rr0_ready", 32'(req_ready), 32'h2);
        tick; to_check;
        chk("rr1_rw", 32'(gpr_rw), 2); chk("rr1_ready", 32'(req_ready), 32'h4);
        tick; to_check;
        chk("rr2_rw", 32'(gpr_rw), 3); chk("rr2_ready", 32'(req_ready), 32'h1);
        // r0 write is accepted but never reaches the register file.
        set_req(0, 1'b1, 5'd0, 32'hDEAD); t_v[1] = 1'b0; t_v[2] = 1'b0;
        #1 chk("r0_ready", 32'(req_ready), 32'h1);
        tick; t_v[0] = 1'b0; set_req(1, 1'b1, 5'd5, 32'h55);
        to_check;
        chk("r0_wr", 32'(gpr_wr), 0); chk("r0_ready1", 32'(req_ready), 32'h2);
        tick; t_v[1] = 1'b0; to_check;
        chk("w5_wr", 32'(gpr_wr), 1); chk("w5_rw", 32'(gpr_rw), 5);
        // Scoreboard: claim 9, retire it, pend drops after the GPR edge.
        claim_valid = 1'b1; claim_rw = 5'd9;
        tick; claim_valid = 1'b0; to_check;
        chk("sb_set", 32'(pend_rs), 1);
        set_req(0, 1'b1, 5'd9, 32'h99);
        tick; t_v[0] = 1'b0; to_check;
`ifdef GPR_WB_FWD_EN
        chk("sb_fwd", 32'(pend_rs), 0);
`else
        chk("sb_hold", 32'(pend_rs), 1);
`endif
        tick; to_check;
        chk("sb_clr", 32'(pend_rs), 0);
        // A fresh claim on the edge that retires 9 keeps it pending.
        claim_valid = 1'b1; tick; claim_valid = 1'b0;
        set_req(0, 1'b1, 5'd9, 32'h91);
        tick; t_v[0] = 1'b0; claim_valid = 1'b1;
        tick; claim_valid = 1'b0; to_check;
        chk("clash_wr", 32'(gpr_wr), 0); chk("clash_pend", 32'(pend_rs), 1);
        // rt hazard while its producer is on the write port.
        claim_valid = 1'b1; claim_rw = 5'd7; rt = 5'd7;
        tick; claim_valid = 1'b0; set_req(1, 1'b1, 5'd7, 32'h1234);
        tick; t_v[1] = 1'b0; to_check;
`ifdef GPR_WB_FWD_EN
        chk("fwd_hit", 32'(fwd_rt_hit), 1); chk("fwd_data", fwd_data, 32'h1234);
        chk("fwd_pend", 32'(pend_rt), 0);
`else
        chk("nofwd_pend", 32'(pend_rt), 1);
`endif
        tick; to_check;
        chk("rt_clr", 32'(pend_rt), 0);
        // Random traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 3000; c++) begin
            tick;
            for (int i = 0; i < 3; i++)
                if (!t_v[i] || acc == i)
                    set_req(i, 1'($urandom % 2), 5'($urandom % 8), $urandom);
            claim_valid = ($urandom % 3) == 0;
            claim_rw = 5'($urandom % 8);
            rs = 5'($urandom % 8);
            rt = 5'($urandom % 8);
            clr_n = ($urandom % 150) != 0;
        end
        clr_n = 1'b1;
        tick; to_check;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
